// File: rtl/comm_signal_responder_pkg.sv
// Shared COMM_PROTOCOL definitions for the fetch-unit encoder and the communication-unit responder.
// Holds the 19-bit signal layout, command codes, responder states and small decode helpers.
package comm_signal_responder_pkg;

  localparam int SIG_W    = 19;
  localparam int CODE_HI  = 18;
  localparam int CODE_LO  = 17;
  localparam int DEP_FLAG = 16;
  localparam int MASK_HI  = 15;

  typedef enum logic [1:0] {
    END   = 2'b00,
    RSVD  = 2'b01,
    START = 2'b10,
    STOP  = 2'b11
  } comm_code_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEP_WAIT = 3'd1,
    ST_RUN      = 3'd2,
    ST_STOPPED  = 3'd3,
    ST_ENDED    = 3'd4
  } comm_state_t;

  function automatic comm_code_t sig_code(input logic [SIG_W-1:0] sig);
    return comm_code_t'(sig[CODE_HI:CODE_LO]);
  endfunction

  // States in which the fetch unit is held off.
  function automatic logic stalls(input comm_state_t st);
    logic result;
    case (st)
      ST_DEP_WAIT, ST_STOPPED, ST_ENDED: result = 1'b1;
      default:                           result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/comm_signal_responder_dep_wait_timer.sv
// DEP_WAIT cycle counter with saturation and timeout compare.
// Only compiled when COMM_DEP_TIMEOUT_EN is defined.
`ifdef COMM_DEP_TIMEOUT_EN
module comm_signal_responder_dep_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Wait counter: cleared on DEP_WAIT entry, counts while waiting, sticks at full scale
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_count_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = i_count_en && (r_count >= EXPIRE_AT);

endmodule
`endif

// File: rtl/comm_signal_responder.sv
// Communication-unit responder for the fetch-unit Start/Stop/End protocol; drives wait_for_next_out.
// Optional forced release out of DEP_WAIT is enabled by defining COMM_DEP_TIMEOUT_EN.
module comm_signal_responder
  import comm_signal_responder_pkg::*;
#(
  parameter int DEP_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 communication_enable_in,
  input  logic [SIG_W-1:0]     communication_signal_in,
  input  logic [DEP_WIDTH-1:0] dep_status_in,
  input  logic                 resume_in,
  output logic                 wait_for_next_out,
  output logic                 process_active_out,
  output logic                 process_end_out,
  output logic [DEP_WIDTH-1:0] dep_mask_out,
  output logic                 protocol_err_out,
  output logic                 dep_timeout_out
);

  comm_state_t          r_state;
  comm_state_t          w_next_state;
  comm_code_t           w_code;
  logic                 w_flag;
  logic [DEP_WIDTH-1:0] w_sig_mask;
  logic [DEP_WIDTH-1:0] w_next_mask;
  logic                 w_start_ok;
  logic                 w_dep_sat;
  logic                 w_expired;
  logic                 w_err;
  logic                 w_tmo;

  assign w_code     = sig_code(communication_signal_in);
  assign w_flag     = communication_signal_in[DEP_FLAG];
  assign w_sig_mask = DEP_WIDTH'(communication_signal_in[MASK_HI:0]);
  assign w_start_ok = !w_flag || ((dep_status_in & w_sig_mask) == w_sig_mask);
  assign w_dep_sat  = (dep_status_in & dep_mask_out) == dep_mask_out;

`ifdef COMM_DEP_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_count;

  assign w_timer_clear = (r_state != ST_DEP_WAIT) && (w_next_state == ST_DEP_WAIT);
  assign w_timer_count = (r_state == ST_DEP_WAIT);

  comm_signal_responder_dep_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dep_wait_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_timer_clear),
    .i_count_en (w_timer_count),
    .o_expired  (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Next-state decode: a sampled command (End > Stop > Start) pre-empts resume and dependency release.
  // An illegal command leaves the state exactly as it was for that cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_mask  = dep_mask_out;
    w_err        = 1'b0;
    w_tmo        = 1'b0;
    if (communication_enable_in) begin
      case (w_code)
        END: begin
          if (r_state != ST_ENDED) w_next_state = ST_ENDED;
          else                     w_err        = 1'b1;
        end
        STOP: begin
          if ((r_state == ST_RUN) || (r_state == ST_DEP_WAIT)) w_next_state = ST_STOPPED;
          else                                                 w_err        = 1'b1;
        end
        START: begin
          if ((r_state == ST_IDLE) || (r_state == ST_RUN)) begin
            w_next_mask  = w_flag ? w_sig_mask : {DEP_WIDTH{1'b0}};
            w_next_state = w_start_ok ? ST_RUN : ST_DEP_WAIT;
          end else begin
            w_err = 1'b1;
          end
        end
        RSVD:    w_err = 1'b1;
        default: w_err = 1'b1;
      endcase
    end else begin
      case (r_state)
        ST_STOPPED: begin
          if (resume_in) w_next_state = ST_RUN;
          else           w_next_state = ST_STOPPED;
        end
        ST_DEP_WAIT: begin
          if (w_dep_sat) begin
            w_next_state = ST_RUN;
          end else if (w_expired) begin
            w_next_state = ST_RUN;
            w_tmo        = 1'b1;
          end else begin
            w_next_state = ST_DEP_WAIT;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  // State register and registered outputs, all decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      wait_for_next_out  <= 1'b0;
      process_active_out <= 1'b0;
      process_end_out    <= 1'b0;
      dep_mask_out       <= {DEP_WIDTH{1'b0}};
      protocol_err_out   <= 1'b0;
      dep_timeout_out    <= 1'b0;
    end else begin
      r_state            <= w_next_state;
      wait_for_next_out  <= stalls(w_next_state);
      process_active_out <= (w_next_state == ST_RUN);
      process_end_out    <= (w_next_state == ST_ENDED);
      dep_mask_out       <= w_next_mask;
      protocol_err_out   <= w_err;
      dep_timeout_out    <= w_tmo;
    end
  end

endmodule

// File: tb/tb_comm_signal_responder.sv
// Self-checking bench for comm_signal_responder: per-scenario stimulus tables, expected outputs
// queued on drive and compared after the following clock edge. Timeout checks follow COMM_DEP_TIMEOUT_EN.
module tb_comm_signal_responder;

  localparam logic [1:0] C_END   = 2'b00;
  localparam logic [1:0] C_RSVD  = 2'b01;
  localparam logic [1:0] C_START = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  typedef struct {
    string       nm;
    logic        rst;
    logic        en;
    logic [1:0]  code;
    logic        flag;
    logic [15:0] mask;
    logic [15:0] st;
    logic        res;
    logic [20:0] exp;
  } step_t;

  logic        clock;
  logic        reset;
  logic        communication_enable_in;
  logic [18:0] communication_signal_in;
  logic [15:0] dep_status_in;
  logic        resume_in;
  logic        wait_for_next_out;
  logic        process_active_out;
  logic        process_end_out;
  logic [15:0] dep_mask_out;
  logic        protocol_err_out;
  logic        dep_timeout_out;

  logic [20:0] obs;
  logic [20:0] exp_q[$];
  int          checks;
  int          failures;

  comm_signal_responder #(
    .DEP_WIDTH      (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .communication_enable_in (communication_enable_in),
    .communication_signal_in (communication_signal_in),
    .dep_status_in           (dep_status_in),
    .resume_in               (resume_in),
    .wait_for_next_out       (wait_for_next_out),
    .process_active_out      (process_active_out),
    .process_end_out         (process_end_out),
    .dep_mask_out            (dep_mask_out),
    .protocol_err_out        (protocol_err_out),
    .dep_timeout_out         (dep_timeout_out)
  );

  assign obs = {wait_for_next_out, process_active_out, process_end_out,
                protocol_err_out, dep_timeout_out, dep_mask_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {wait, active, end, err, timeout, mask}
  function automatic logic [20:0] ev(logic w, logic a, logic e, logic er, logic t, logic [15:0] m);
    return {w, a, e, er, t, m};
  endfunction

  function automatic step_t mk(string nm, logic rst, logic en, logic [1:0] code, logic flag,
                               logic [15:0] mask, logic [15:0] st, logic res, logic [20:0] exp);
    step_t s;
    s.nm = nm; s.rst = rst; s.en = en; s.code = code; s.flag = flag;
    s.mask = mask; s.st = st; s.res = res; s.exp = exp;
    return s;
  endfunction

  task automatic apply(input step_t s);
    reset                   = s.rst;
    communication_enable_in = s.en;
    communication_signal_in = {s.code, s.flag, s.mask};
    dep_status_in           = s.st;
    resume_in               = s.res;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("reset_c1", 1'b1, 1'b1, C_START, 1'b1, 16'h00FF, 16'h0000, 1'b1, ev(0,0,0,0,0,16'h0000)));
    s.push_back(mk("reset_c2", 1'b1, 1'b1, C_STOP,  1'b0, 16'h0000, 16'h0000, 1'b1, ev(0,0,0,0,0,16'h0000)));
    s.push_back(mk("idle_hold", 1'b0, 1'b0, C_START, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(0,0,0,0,0,16'h0000)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_start_nodep();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("start_flag0", 1'b0, 1'b1, C_START, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,1,0,0,0,16'h0000)));
    s.push_back(mk("start_flag0_mask0", 1'b0, 1'b1, C_START, 1'b0, 16'hFFFF, 16'h0000, 1'b0, ev(0,1,0,0,0,16'h0000)));
    s.push_back(mk("run_hold", 1'b0, 1'b0, C_RSVD, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,1,0,0,0,16'h0000)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_dep_wait();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("start_dep_met", 1'b0, 1'b1, C_START, 1'b1, 16'h0003, 16'h0007, 1'b0, ev(0,1,0,0,0,16'h0003)));
    s.push_back(mk("start_dep_wait", 1'b0, 1'b1, C_START, 1'b1, 16'h0005, 16'h0001, 1'b0, ev(1,0,0,0,0,16'h0005)));
    s.push_back(mk("dep_partial_1", 1'b0, 1'b0, C_START, 1'b0, 16'h0000, 16'h0001, 1'b0, ev(1,0,0,0,0,16'h0005)));
    s.push_back(mk("dep_partial_2", 1'b0, 1'b0, C_START, 1'b0, 16'h0000, 16'h0004, 1'b0, ev(1,0,0,0,0,16'h0005)));
    s.push_back(mk("dep_satisfied", 1'b0, 1'b0, C_START, 1'b0, 16'h0000, 16'h0005, 1'b0, ev(0,1,0,0,0,16'h0005)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_stop_resume();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("stop_in_run", 1'b0, 1'b1, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0005)));
    s.push_back(mk("stop_and_resume", 1'b0, 1'b1, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(1,0,0,1,0,16'h0005)));
    s.push_back(mk("stopped_hold", 1'b0, 1'b0, C_STOP, 1'b0, 16'h0000, 16'hFFFF, 1'b0, ev(1,0,0,0,0,16'h0005)));
    s.push_back(mk("resume", 1'b0, 1'b0, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(0,1,0,0,0,16'h0005)));
    s.push_back(mk("resume_in_run", 1'b0, 1'b0, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(0,1,0,0,0,16'h0005)));
    s.push_back(mk("start_dep_wait", 1'b0, 1'b1, C_START, 1'b1, 16'h0008, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0008)));
    s.push_back(mk("stop_beats_dep", 1'b0, 1'b1, C_STOP, 1'b0, 16'h0000, 16'h0008, 1'b0, ev(1,0,0,0,0,16'h0008)));
    s.push_back(mk("resume_no_recheck", 1'b0, 1'b0, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(0,1,0,0,0,16'h0008)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_end();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("start_dep_wait", 1'b0, 1'b1, C_START, 1'b1, 16'h0010, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0010)));
    s.push_back(mk("end_beats_dep", 1'b0, 1'b1, C_END, 1'b0, 16'h0000, 16'h0010, 1'b0, ev(1,0,1,0,0,16'h0010)));
    s.push_back(mk("start_in_ended", 1'b0, 1'b1, C_START, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,1,1,0,16'h0010)));
    s.push_back(mk("ended_hold", 1'b0, 1'b0, C_START, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,1,0,0,16'h0010)));
    s.push_back(mk("end_in_ended", 1'b0, 1'b1, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,1,1,0,16'h0010)));
    s.push_back(mk("resume_in_ended", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b1, ev(1,0,1,0,0,16'h0010)));
    s.push_back(mk("reset_from_ended", 1'b1, 1'b1, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,0,0,16'h0000)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_reserved();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("rsvd_en1", 1'b0, 1'b1, C_RSVD, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,1,0,16'h0000)));
    s.push_back(mk("rsvd_en0", 1'b0, 1'b0, C_RSVD, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,0,0,16'h0000)));
    s.push_back(mk("stop_in_idle", 1'b0, 1'b1, C_STOP, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,1,0,16'h0000)));
    s.push_back(mk("start_from_idle", 1'b0, 1'b1, C_START, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,1,0,0,0,16'h0000)));
    s.push_back(mk("rsvd_in_run", 1'b0, 1'b1, C_RSVD, 1'b1, 16'h0003, 16'h0000, 1'b0, ev(0,1,0,1,0,16'h0000)));
    s.push_back(mk("start_dep_wait", 1'b0, 1'b1, C_START, 1'b1, 16'h0001, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0001)));
    s.push_back(mk("start_in_dep_wait", 1'b0, 1'b1, C_START, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,0,1,0,16'h0001)));
    s.push_back(mk("end_from_dep_wait", 1'b0, 1'b1, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,1,0,0,16'h0001)));
    s.push_back(mk("reset_again", 1'b1, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,0,0,16'h0000)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    logic [20:0] ex;
    s.push_back(mk("tmo_enter", 1'b0, 1'b1, C_START, 1'b1, 16'h0002, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0002)));
`ifdef COMM_DEP_TIMEOUT_EN
    for (int k = 0; k < 3; k++)
      s.push_back(mk("tmo_waiting", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0002)));
    s.push_back(mk("tmo_pulse", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,1,0,0,1,16'h0002)));
    s.push_back(mk("tmo_pulse_clears", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,1,0,0,0,16'h0002)));
    s.push_back(mk("tmo_reenter", 1'b0, 1'b1, C_START, 1'b1, 16'h0002, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0002)));
    for (int k = 0; k < 3; k++)
      s.push_back(mk("tmo_rewaiting", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0002)));
    s.push_back(mk("tmo_sat_wins", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0002, 1'b0, ev(0,1,0,0,0,16'h0002)));
`else
    for (int k = 0; k < 6; k++)
      s.push_back(mk("no_tmo_waiting", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(1,0,0,0,0,16'h0002)));
    s.push_back(mk("no_tmo_sat", 1'b0, 1'b0, C_END, 1'b0, 16'h0000, 16'h0002, 1'b0, ev(0,1,0,0,0,16'h0002)));
`endif
    s.push_back(mk("tmo_reset", 1'b1, 1'b0, C_END, 1'b0, 16'h0000, 16'h0000, 1'b0, ev(0,0,0,0,0,16'h0000)));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(s[i].exp); tick();
      ex = exp_q.pop_front(); checks++;
      if (obs !== ex) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", s[i].nm, obs, ex);
      end
    end
  endtask

  initial begin
    checks                  = 0;
    failures                = 0;
    reset                   = 1'b1;
    communication_enable_in = 1'b0;
    communication_signal_in = 19'h00000;
    dep_status_in           = 16'h0000;
    resume_in               = 1'b0;
    test_reset();
    test_start_nodep();
    test_dep_wait();
    test_stop_resume();
    test_end();
    test_reserved();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/comm_signal_responder.md
Name: comm_signal_responder

Overview:
- Communication-unit end of the fetch-unit process-control protocol.
- Consumes the 19-bit communication signal (Start/Stop/End + dependency) emitted by the instruction fetch unit.
- Drives wait_for_next back to the fetch unit, stalling it while dependencies are outstanding, while stopped, or after End.
- Sits between the fetch unit and the process scheduler, which supplies dependency-completion status and resume.

Parameters:
- DEP_WIDTH, 16: width of the dependency mask field (signal bits [15:0]).
- TIMEOUT_CYCLES, 64: maximum DEP_WAIT cycles before forced release (only with the optional feature).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- communication_enable_in  in  1  qualifies communication_signal_in; signal is ignored when 0.
- communication_signal_in  in  19  [18:17] code, [16] dependency flag, [15:0] dependency mask.
- dep_status_in  in  DEP_WIDTH  bit i = 1 means process i has completed.
- resume_in  in  1  scheduler request to leave STOPPED.
- wait_for_next_out  out  1  1 = fetch unit must hold.
- process_active_out  out  1  1 while in RUN.
- process_end_out  out  1  sticky after End.
- dep_mask_out  out  DEP_WIDTH  latched dependency mask.
- protocol_err_out  out  1  one-cycle pulse on an illegal command.
- dep_timeout_out  out  1  one-cycle pulse on forced release (tied 0 without the optional feature).

Behaviour:
- Codes: 10 Start, 11 Stop, 00 End, 01 reserved.
- A command is sampled when communication_enable_in is 1. All outputs are registered and respond on the cycle after sampling.
- Reset: state IDLE. All outputs 0, dep_mask_out 0, wait counter 0. Reset mid-operation aborts any state immediately.
- States are IDLE, DEP_WAIT, RUN, STOPPED, ENDED.
  - wait_for_next_out = 1 in DEP_WAIT, STOPPED and ENDED; 0 in IDLE and RUN.
- IDLE/RUN + Start:
  - Latch mask into dep_mask_out.
  - If flag = 0, or (dep_status_in & mask) == mask in the same cycle: go to RUN.
  - Otherwise: go to DEP_WAIT and clear the counter.
  - A Start with flag = 0 latches a mask of 0.
- DEP_WAIT:
  - Each cycle, test (dep_status_in & dep_mask_out) == dep_mask_out; when true, go to RUN. wait_for_next_out drops the following cycle.
  - Counter increments each cycle and saturates at its maximum.
- RUN + Stop, or DEP_WAIT + Stop: go to STOPPED. The latched mask is retained.
- STOPPED + resume_in: go to RUN. The dependency is not re-checked.
- Any state except ENDED + End: go to ENDED. process_end_out stays 1 and wait_for_next_out stays 1 until reset.
- Illegal commands pulse protocol_err_out for one cycle; state is unchanged.
  - Start in DEP_WAIT, STOPPED or ENDED.
  - Stop in IDLE, STOPPED or ENDED.
  - Reserved code 01.
  - Any command in ENDED.
- Simultaneous events, in priority order:
  1. reset
  2. End
  3. Stop (beats resume_in and dependency satisfaction)
  4. resume_in / dependency satisfaction
- resume_in outside STOPPED is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: COMM_DEP_TIMEOUT_EN.
- Defined:
  - When the DEP_WAIT counter reaches TIMEOUT_CYCLES-1 without satisfaction, go to RUN and pulse dep_timeout_out for one cycle.
  - Satisfaction in that same cycle wins; no pulse is raised.
- Undefined:
  - No timeout; DEP_WAIT persists indefinitely.
  - dep_timeout_out is tied to 0 and the counter is omitted.

Decomposition:
- Shared package COMM_PROTOCOL contains:
  - typedef enum logic[1:0] comm_code_t {END=2'b00, RSVD=2'b01, START=2'b10, STOP=2'b11}.
  - Field-position constants CODE_HI=18, CODE_LO=17, DEP_FLAG=16, MASK_HI=15.
  - typedef enum comm_state_t for the five states.
- The fetch unit's encoder imports the same package.
- One sub-module, dep_wait_timer: counter, saturation and timeout compare, compiled only under COMM_DEP_TIMEOUT_EN.

Test Plan:
- Reset held 2 cycles → all outputs 0. Then Start with flag 0 (signal 19'b10_0_0000000000000000) → process_active_out = 1 and wait_for_next_out = 0 one cycle later.
- Start with flag 1, mask 16'h0005, dep_status_in 16'h0001 → wait_for_next_out = 1. Set dep_status_in 16'h0005 at cycle 10 → wait_for_next_out = 0 at cycle 11, state RUN.
- In RUN, Stop → STOPPED, wait_for_next_out = 1. Stop and resume_in in the same cycle → stays STOPPED. resume_in alone → RUN.
- End from DEP_WAIT → process_end_out = 1. A later Start → protocol_err_out pulses once and state stays ENDED. Reset → IDLE, all outputs 0.
- Reserved code 01 with enable 1 → one protocol_err_out pulse. Same code with enable 0 → no pulse, no state change.
- COMM_DEP_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mask 16'h0002, dep_status_in 0 → dep_timeout_out pulses 4 cycles after entering DEP_WAIT, then state RUN.
